pipe_stage_skid: RTL and testbench

- Parametrised, flushable pipeline stage register that succeeds the fixed-field decode-to-execute latch.
- Carries an opaque payload of DATA_W bits between any two pipeline stages.
- Uses a valid/ready handshake instead of a global stall vector.
- A two-entry skid buffer keeps in_ready registered, so back-pressure never forms a combinational path through the stage. Flush (branch squash) and bubble insertion are built in.

---
 rtl/pipe_stage_skid.sv | 100 ++++++++++
 tb/tb_pipe_stage_skid.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Flushable valid/ready pipeline stage with a two-entry skid buffer.
// in_ready, out_valid and out_data all come straight from flops.
module pipe_stage_skid #(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] NOP_VALUE  = '0,
    parameter bit                BUBBLE_NOP = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q;
    logic              in_fire, out_fire;
    logic [DATA_W-1:0] main_idle;

    assign in_fire   = in_valid & in_ready_q & rdy;
    assign out_fire  = (state_q != EMPTY) & out_ready & rdy;
    // Value main takes whenever the stage drops to EMPTY.
    assign main_idle = BUBBLE_NOP ? NOP_VALUE : main_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= NOP_VALUE;
            skid_q     <= NOP_VALUE;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Anything out_fire took this cycle is already consumed; squash the rest.
            state_d = EMPTY;
            main_d  = main_idle;
            skid_d  = NOP_VALUE;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = BUSY;
                        main_d  = in_data;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                        main_d  = main_idle;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = NOP_VALUE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a queue holds accepted payloads in
// order; each downstream transfer pops and compares, flush empties the queue.
module tb_pipe_stage_skid;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic        h_in_ready, h_out_valid;
    logic [31:0] h_out_data;
    logic [1:0]  h_occupancy;

    logic [31:0] sb[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(32), .NOP_VALUE(NOP), .BUBBLE_NOP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    // Same stimulus, but the payload is held rather than replaced by NOP.
    pipe_stage_skid #(.DATA_W(32), .NOP_VALUE(NOP), .BUBBLE_NOP(1'b0)) dut_hold (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(h_in_ready), .in_data(in_data),
        .out_valid(h_out_valid), .out_ready(out_ready), .out_data(h_out_data),
        .occupancy(h_occupancy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drives one cycle of inputs, scores transfers at the negedge, then checks
    // the handshake outputs against the scoreboard depth just after the edge.
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic ordy,
                                 input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        rdy       = r;
        flush     = f;
        @(negedge clk);
        if (out_valid && ordy && r) begin
            if (sb.size() == 0) checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
            else checkOutput("sb_data", out_data, sb.pop_front());
        end
        if (f) sb.delete();
        else if (v && in_ready && r) sb.push_back(d);
        @(posedge clk);
        #1;
        checkOutput("occ_model", 32'(occupancy), 32'(sb.size()));
        checkOutput("valid_model", 32'(out_valid), 32'(sb.size() != 0));
        checkOutput("ready_model", 32'(in_ready), 32'(sb.size() < 2));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        #12;
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_data", out_data, NOP);
        checkOutput("rst_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_occ", 32'(occupancy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] streaming 1,2,3");
        applyStimulus(1'b1, 32'd1, 1'b1, 1'b1, 1'b0);
        checkOutput("t1_data1", out_data, 32'd1);
        applyStimulus(1'b1, 32'd2, 1'b1, 1'b1, 1'b0);
        checkOutput("t1_data2", out_data, 32'd2);
        applyStimulus(1'b1, 32'd3, 1'b1, 1'b1, 1'b0);
        checkOutput("t1_data3", out_data, 32'd3);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("t1_bubble", out_data, NOP);

        $display("[TB] back-pressure");
        applyStimulus(1'b1, 32'hAA, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hBB, 1'b0, 1'b1, 1'b0);
        checkOutput("t2_full_occ", 32'(occupancy), 32'd2);
        checkOutput("t2_hold_aa", out_data, 32'hAA);
        applyStimulus(1'b1, 32'hDD, 1'b0, 1'b1, 1'b0);
        checkOutput("t2_still_aa", out_data, 32'hAA);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("t2_ready_back", 32'(in_ready), 32'd1);
        checkOutput("t2_data_bb", out_data, 32'hBB);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);

        $display("[TB] flush while full");
        applyStimulus(1'b1, 32'hAA, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hBB, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hCC, 1'b0, 1'b1, 1'b1);
        checkOutput("t3_data", out_data, NOP);
        checkOutput("t3_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("t3_no_cc", out_data, NOP);

        $display("[TB] rdy low freeze");
        applyStimulus(1'b1, 32'h55, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h66, 1'b1, 1'b0, 1'b0);
            checkOutput("t4_freeze", out_data, 32'h55);
        end
        applyStimulus(1'b1, 32'h66, 1'b1, 1'b1, 1'b0);
        checkOutput("t4_resume", out_data, 32'h66);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);

        $display("[TB] async reset while full");
        applyStimulus(1'b1, 32'hAA, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hBB, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_valid", 32'(out_valid), 32'd0);
        checkOutput("t5_data", out_data, NOP);
        checkOutput("t5_ready", 32'(in_ready), 32'd1);
        checkOutput("t5_occ", 32'(occupancy), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 32'h99, 1'b1, 1'b1, 1'b0);
        checkOutput("t5_after_rst", out_data, 32'h99);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);

        $display("[TB] hold-last-value variant");
        applyStimulus(1'b1, 32'h77, 1'b0, 1'b1, 1'b0);
        checkOutput("t6_valid", 32'(h_out_valid), 32'd1);
        checkOutput("t6_data", h_out_data, 32'h77);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("t6_drained", 32'(h_out_valid), 32'd0);
        checkOutput("t6_hold", h_out_data, 32'h77);
        checkOutput("t6_nop_side", out_data, NOP);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
        checkOutput("t6_flush_hold", h_out_data, 32'h77);
        checkOutput("t6_flush_occ", 32'(h_occupancy), 32'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("final_empty", 32'(occupancy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
